// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: sequencer state encoding, timing derivation
// from the input clock, and the pixel-to-wire byte ordering.
package ws2812_pkg;

  // Frame sequencer states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_LOAD    = 3'd2;
  localparam logic [2:0] ST_TRIGGER = 3'd3;
  localparam logic [2:0] ST_STREAM  = 3'd4;
  localparam logic [2:0] ST_DRAIN   = 3'd5;
  localparam logic [2:0] ST_GUARD   = 3'd6;

  // Lowest clock at which the serializer bit timing can be met
  localparam int MIN_INPUT_CLOCK = 12_000_000;

  // Refresh period expressed as the terminal count of a 0-based counter
  function automatic int period_cycles(input int clk_hz, input int refresh_hz);
    return clk_hz / refresh_hz - 1;
  endfunction

  // Whole clock cycles in a given number of microseconds (truncated)
  function automatic int us_to_cycles(input int clk_hz, input int us);
    return int'((longint'(clk_hz) * longint'(us)) / longint'(1_000_000));
  endfunction

  // Wire order is G, R, B; pixel word is {R, G, B}
  function automatic logic [7:0] grb_byte(input logic [23:0] pix, input logic [1:0] idx);
    case (idx)
      2'd0:    return pix[15:8];
      2'd1:    return pix[23:16];
      default: return pix[7:0];
    endcase
  endfunction

endpackage

// File: rtl/ws2812_refresh_timer.sv
// Free-running refresh period counter; tick marks the terminal count.
module ws2812_refresh_timer
  import ws2812_pkg::*;
#(
  parameter int PERIOD = 199_999
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (PERIOD < 1) ? 1 : $clog2(PERIOD + 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(PERIOD));

  // Count 0..PERIOD and wrap; ignores enable so frame cadence stays fixed
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Frame sequencer: reads the framebuffer once per refresh tick, hands bytes
// to the WS2812 serializer in G,R,B order and holds off for the latch gap.
module ws2812_frame_sequencer
  import ws2812_pkg::*;
#(
  parameter int INPUT_CLOCK  = 12_000_000,
  parameter int NUM_LEDS     = 8,
  parameter int REFRESH_HZ   = 60,
  parameter int GUARD_CYCLES = us_to_cycles(INPUT_CLOCK, 80),
  localparam int AW          = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          fb_rd_en,
  output logic [AW-1:0] fb_rd_addr,
  input  logic [23:0]   fb_rd_data,
  output logic          ws_trigger,
  output logic [7:0]    ws_data,
  output logic          ws_data_valid,
  input  logic          ws_data_request,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_overrun
);
  localparam int GW = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);
  localparam int GL = (GUARD_CYCLES < 1) ? 0 : GUARD_CYCLES - 1;

  logic [2:0]    state;
  logic [23:0]   pixel;
  logic [1:0]    byte_idx;
  logic          refill;    // next byte of the current pixel goes out this cycle
  logic          rd_pend;   // fb_rd_data carries the next pixel this cycle
  logic [GW-1:0] guard_cnt;
  logic          tick;
  logic          consume;
  logic          last_px;

  ws2812_refresh_timer #(
    .PERIOD(period_cycles(INPUT_CLOCK, REFRESH_HZ))
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign consume    = ws_data_request && ws_data_valid;
  assign last_px    = (fb_rd_addr == AW'(NUM_LEDS - 1));
  assign ws_trigger = (state == ST_TRIGGER);
  assign busy       = (state != ST_IDLE);

  // Frame FSM with registered byte/handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      pixel         <= '0;
      byte_idx      <= '0;
      refill        <= 1'b0;
      rd_pend       <= 1'b0;
      guard_cnt     <= '0;
      fb_rd_en      <= 1'b0;
      fb_rd_addr    <= '0;
      ws_data       <= '0;
      ws_data_valid <= 1'b0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      fb_rd_en      <= 1'b0;
      frame_done    <= 1'b0;
      refill        <= 1'b0;
      rd_pend       <= fb_rd_en;
      // Any tick outside IDLE (including the GUARD->IDLE cycle) is lost
      frame_overrun <= tick && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (tick && enable) begin
            fb_rd_en   <= 1'b1;
            fb_rd_addr <= '0;
            state      <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          pixel         <= fb_rd_data;
          ws_data       <= grb_byte(fb_rd_data, 2'd0);
          ws_data_valid <= 1'b1;
          byte_idx      <= 2'd0;
          state         <= ST_TRIGGER;
        end
        ST_TRIGGER: state <= ST_STREAM;
        ST_STREAM: begin
          // refill and rd_pend only occur while valid is low, so they never
          // collide with a consumption in the same cycle
          if (consume) begin
            ws_data_valid <= 1'b0;
            if (byte_idx != 2'd2) begin
              refill <= 1'b1;
            end else if (last_px) begin
              state <= ST_DRAIN;
            end else begin
              fb_rd_en   <= 1'b1;
              fb_rd_addr <= fb_rd_addr + 1'b1;
            end
          end
          if (refill) begin
            ws_data       <= grb_byte(pixel, byte_idx + 2'd1);
            byte_idx      <= byte_idx + 2'd1;
            ws_data_valid <= 1'b1;
          end
          if (rd_pend) begin
            pixel         <= fb_rd_data;
            ws_data       <= grb_byte(fb_rd_data, 2'd0);
            byte_idx      <= 2'd0;
            ws_data_valid <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // A request with nothing pending means the serializer is in its tail
          if (ws_data_request && !ws_data_valid) begin
            guard_cnt <= GW'(GL);
            state     <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          if (guard_cnt == '0) begin
            frame_done <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            guard_cnt <= guard_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Directed bench: three sequencer instances (2 LEDs, 1 LED, 1 LED with a
// refresh period shorter than a frame) driven by a simple serializer model.
module tb_ws2812_frame_sequencer;
  localparam int CLK_HZ = 12_000_000;
  localparam int G      = 20;   // guard cycles for every instance
  localparam int P0     = 600;  // refresh period (cycles), REFRESH_HZ=20000
  localparam int P2     = 40;   // refresh period (cycles), REFRESH_HZ=300000

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]       en, req, rd_en, trig, vld, busy, done, ovr;
  logic [2:0][7:0]  data;
  logic [2:0][0:0]  addr;
  logic [2:0][23:0] rd_data;
  logic [23:0]      fb [3][2];

  ws2812_frame_sequencer #(.INPUT_CLOCK(CLK_HZ), .NUM_LEDS(2), .REFRESH_HZ(20000), .GUARD_CYCLES(G)) u0 (
    .clk(clk), .rst(rst), .enable(en[0]), .fb_rd_en(rd_en[0]), .fb_rd_addr(addr[0]),
    .fb_rd_data(rd_data[0]), .ws_trigger(trig[0]), .ws_data(data[0]), .ws_data_valid(vld[0]),
    .ws_data_request(req[0]), .busy(busy[0]), .frame_done(done[0]), .frame_overrun(ovr[0]));

  ws2812_frame_sequencer #(.INPUT_CLOCK(CLK_HZ), .NUM_LEDS(1), .REFRESH_HZ(20000), .GUARD_CYCLES(G)) u1 (
    .clk(clk), .rst(rst), .enable(en[1]), .fb_rd_en(rd_en[1]), .fb_rd_addr(addr[1]),
    .fb_rd_data(rd_data[1]), .ws_trigger(trig[1]), .ws_data(data[1]), .ws_data_valid(vld[1]),
    .ws_data_request(req[1]), .busy(busy[1]), .frame_done(done[1]), .frame_overrun(ovr[1]));

  ws2812_frame_sequencer #(.INPUT_CLOCK(CLK_HZ), .NUM_LEDS(1), .REFRESH_HZ(300000), .GUARD_CYCLES(G)) u2 (
    .clk(clk), .rst(rst), .enable(en[2]), .fb_rd_en(rd_en[2]), .fb_rd_addr(addr[2]),
    .fb_rd_data(rd_data[2]), .ws_trigger(trig[2]), .ws_data(data[2]), .ws_data_valid(vld[2]),
    .ws_data_request(req[2]), .busy(busy[2]), .frame_done(done[2]), .frame_overrun(ovr[2]));

  // Framebuffer RAMs: one-cycle read latency
  always @(posedge clk)
    for (int k = 0; k < 3; k++)
      if (rd_en[k]) rd_data[k] <= fb[k][addr[k]];

  // Event counters per instance
  int n_trig [3] = '{0, 0, 0};
  int n_rd   [3] = '{0, 0, 0};
  int n_busy [3] = '{0, 0, 0};
  int n_ovr  [3] = '{0, 0, 0};
  always @(posedge clk)
    for (int k = 0; k < 3; k++) begin
      n_trig[k] <= n_trig[k] + int'(trig[k]);
      n_rd[k]   <= n_rd[k]   + int'(rd_en[k]);
      n_busy[k] <= n_busy[k] + int'(busy[k]);
      n_ovr[k]  <= n_ovr[k]  + int'(ovr[k]);
    end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Wait for the FETCH read, then expect the trigger two cycles later
  task automatic wait_frame(input int k, input int budget, input string tag);
    int i;
    i = 0;
    while (rd_en[k] !== 1'b1 && i < budget) begin cyc(1); i++; end
    chk({tag, "_start"}, rd_en[k], 1);
    chk({tag, "_addr0"}, addr[k], 0);
    cyc(2);
    chk({tag, "_trig"}, trig[k], 1);
  endtask

  // Serializer model: request each byte after 'gap' idle cycles
  task automatic serve(input int k, input int n, input int gap, input logic [47:0] exp, input string tag);
    logic hold_ok;
    hold_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < gap; j++) begin
        cyc(1);
        if (j >= 3 && (vld[k] !== 1'b1 || data[k] !== exp[47-8*i -: 8])) hold_ok = 1'b0;
      end
      req[k] = 1'b1;
      chk($sformatf("%s_b%0d", tag, i), {vld[k], data[k]}, {1'b1, exp[47-8*i -: 8]});
      cyc(1);
      req[k] = 1'b0;
    end
    chk({tag, "_hold"}, hold_ok, 1);
  endtask

  // Tail request with nothing pending, then time the guard gap
  task automatic finish_frame(input int k, input int gap, input string tag);
    int i;
    cyc(gap);
    req[k] = 1'b1;
    chk({tag, "_tail_vld"}, vld[k], 0);
    chk({tag, "_tail_busy"}, busy[k], 1);
    cyc(1);
    req[k] = 1'b0;
    i = 0;
    while (done[k] !== 1'b1 && i < G + 50) begin cyc(1); i++; end
    chk({tag, "_guard"}, i, G);
    chk({tag, "_idle"}, busy[k], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int s_trig, s_rd, s_busy, s_ovr, d_busy, d_ovr;

  initial begin
    rst = 1'b1; en = '0; req = '0;
    fb[0][0] = 24'h112233; fb[0][1] = 24'hAABBCC;
    fb[1][0] = 24'h800001; fb[1][1] = 24'h000000;
    fb[2][0] = 24'h123456; fb[2][1] = 24'h000000;
    cyc(3);
    chk("rst_busy",  busy,  0);
    chk("rst_vld",   vld,   0);
    chk("rst_trig",  trig,  0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_data",  data,  0);
    chk("rst_addr",  addr,  0);
    chk("rst_flags", {done, ovr}, 0);
    rst = 1'b0;

    // Two-pixel frame, fast requests
    s_trig = n_trig[0];
    en[0] = 1'b1;
    wait_frame(0, P0 + 50, "a");
    serve(0, 6, 4, 48'h221133_BBAACC, "a");
    finish_frame(0, 4, "a");
    en[0] = 1'b0;
    cyc(2);
    chk("a_one_trig", n_trig[0] - s_trig, 1);

    // Disabled across a tick: nothing starts
    s_rd = n_rd[0]; s_busy = n_busy[0];
    cyc(P0 + 50);
    chk("b_no_fetch", n_rd[0] - s_rd, 0);
    chk("b_no_busy",  n_busy[0] - s_busy, 0);

    // Enable dropped mid-frame, slow requests: frame still completes
    en[0] = 1'b1;
    wait_frame(0, P0 + 50, "c");
    en[0] = 1'b0;
    serve(0, 6, 40, 48'h221133_BBAACC, "c");
    finish_frame(0, 10, "c");

    // Single LED
    en[1] = 1'b1;
    wait_frame(1, P0 + 50, "d");
    en[1] = 1'b0;
    serve(1, 3, 6, 48'h008001_000000, "d");
    finish_frame(1, 6, "d");

    // Period shorter than the frame: every tick while busy is dropped
    s_busy = n_busy[2]; s_ovr = n_ovr[2]; s_trig = n_trig[2];
    en[2] = 1'b1;
    wait_frame(2, P2 + 10, "e");
    en[2] = 1'b0;
    serve(2, 3, 30, 48'h341256_000000, "e");
    finish_frame(2, 30, "e");
    cyc(3);
    d_busy = n_busy[2] - s_busy;
    d_ovr  = n_ovr[2] - s_ovr;
    chk("e_overrun", d_ovr, d_busy / P2);
    chk("e_dropped", (d_ovr >= 2), 1);
    chk("e_one_trig", n_trig[2] - s_trig, 1);

    // Reset while pixel 1 is pending
    en[0] = 1'b1;
    wait_frame(0, P0 + 50, "f");
    serve(0, 3, 4, 48'h221133_000000, "f");
    cyc(4);
    chk("f_px1_addr", addr[0], 1);
    chk("f_px1_byte", {vld[0], data[0]}, {1'b1, 8'hBB});
    rst = 1'b1;
    cyc(1);
    chk("f_rst_busy", busy[0], 0);
    chk("f_rst_outs", {rd_en[0], trig[0], vld[0], done[0], ovr[0]}, 0);
    chk("f_rst_data", data[0], 0);
    rst = 1'b0;
    wait_frame(0, P0 + 50, "f_re");
    en[0] = 1'b0;
    serve(0, 6, 4, 48'h221133_BBAACC, "f_re");
    finish_frame(0, 4, "f_re");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
